// File: rtl/lag_glyph_pkg.sv
// Shared types and constants for the lag readout glyph sequencer.
// Field byte bases place each 5-digit readout, with a decimal-point gap, in the 35-byte line.
package lag_glyph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    localparam int          DIGITS           = 5;
    localparam int          NUM_FIELDS       = 4;
    localparam logic [19:0] BCD_MAX_SENTINEL = 20'h99999;

    localparam logic [5:0] FIELD_BASE_0 = 6'd24;
    localparam logic [5:0] FIELD_BASE_1 = 6'd17;
    localparam logic [5:0] FIELD_BASE_2 = 6'd10;
    localparam logic [5:0] FIELD_BASE_3 = 6'd3;

    // Digits 2..4 shift up one byte to leave the decimal point untouched.
    function automatic logic [5:0] byte_index(input logic [1:0] field, input logic [2:0] digit);
        logic [5:0] fb;
        case (field)
            2'd0:    fb = FIELD_BASE_0;
            2'd1:    fb = FIELD_BASE_1;
            2'd2:    fb = FIELD_BASE_2;
            default: fb = FIELD_BASE_3;
        endcase
        return fb + {3'b000, digit} + ((digit >= 3'd2) ? 6'd1 : 6'd0);
    endfunction

endpackage

// File: rtl/lag_glyph_sequencer_tag_pipe.sv
// Fixed-depth valid+tag shift register matching the ROM read latency.
// Latency DEPTH cycles; no backpressure, one entry accepted per cycle.
module lag_glyph_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_vld,
    input  logic [5:0] i_tag,
    output logic       o_vld,
    output logic [5:0] o_tag,
    output logic       o_empty
);

    logic [DEPTH-1:0] r_vld;
    logic [5:0]       r_tag [DEPTH];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld   = r_vld[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];
    assign o_empty = ~|r_vld;

endmodule

// File: rtl/lag_glyph_sequencer.sv
// Per-scanline glyph fetch sequencer: one ROM read per digit, bytes written back after ROM_LATENCY.
// Runs to completion once started; later starts are ignored until the done cycle.
module lag_glyph_sequencer
    import lag_glyph_pkg::*;
#(
    parameter int         ROM_LATENCY        = 2,
    parameter logic [7:0] CHAR_BASE          = 8'h30,
    parameter logic [3:0] ZERO_SENTINEL_MASK = 4'b0100
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [3:0]  i_row,
    input  logic [79:0] i_bcdcount,
    output logic        o_rom_rd,
    output logic [10:0] o_rom_addr,
    input  logic [7:0]  i_rom_q,
    output logic        o_wr_en,
    output logic [5:0]  o_wr_byte,
    output logic [7:0]  o_wr_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_skipped
);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_field;
    logic [2:0]  r_digit;
    logic [79:0] r_snap;
    logic [10:0] r_base;
    logic [3:0]  r_skipped;

    logic [19:0] w_field_val;
    logic [3:0]  w_digit_val;
    logic        w_invalid;
    logic        w_accept;
    logic        w_last_digit;
    logic        w_last_field;
    logic [11:0] w_base_full;
    logic        w_pipe_vld;
    logic [5:0]  w_pipe_tag;
    logic        w_pipe_empty;

    assign w_field_val  = r_snap[7'(r_field) * 7'd20 +: 20];
    assign w_digit_val  = w_field_val[{r_digit, 2'b00} +: 4];
    assign w_invalid    = ZERO_SENTINEL_MASK[r_field] ? (w_field_val == 20'h0)
                                                      : (w_field_val == BCD_MAX_SENTINEL);
    assign w_last_digit = (r_digit == 3'(DIGITS - 1));
    assign w_last_field = (r_field == 2'(NUM_FIELDS - 1));
    assign w_base_full  = {CHAR_BASE, 4'b0000} + {8'h00, i_row};
    assign w_accept     = i_start && !o_busy;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_rom_rd    = 1'b0;
        o_done      = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                o_busy = 1'b1;
                if (!w_invalid)       w_state_nxt = ST_ISSUE;
                else if (w_last_field) w_state_nxt = ST_DRAIN;
            end
            ST_ISSUE: begin
                o_busy   = 1'b1;
                o_rom_rd = 1'b1;
                if (w_last_digit) w_state_nxt = w_last_field ? ST_DRAIN : ST_CHECK;
            end
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    o_done      = 1'b1;
                    w_state_nxt = i_start ? ST_CHECK : ST_IDLE;
                end else begin
                    o_busy = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_field   <= '0;
            r_digit   <= '0;
            r_snap    <= '0;
            r_base    <= '0;
            r_skipped <= '0;
        end else if (w_accept) begin
            r_snap    <= i_bcdcount;
            r_base    <= w_base_full[10:0];
            r_skipped <= '0;
            r_field   <= '0;
            r_digit   <= '0;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    r_digit <= '0;
                    if (w_invalid) begin
                        r_skipped[r_field] <= 1'b1;
                        r_field            <= r_field + 2'd1;
                    end
                end
                ST_ISSUE: begin
                    if (w_last_digit) begin
                        r_digit <= '0;
                        r_field <= r_field + 2'd1;
                    end else begin
                        r_digit <= r_digit + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rom_addr = o_rom_rd ? (r_base + {3'b000, w_digit_val, 4'b0000}) : 11'h0;

    lag_glyph_tag_pipe #(
        .DEPTH (ROM_LATENCY)
    ) u_tag_pipe (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_vld     (o_rom_rd),
        .i_tag     (byte_index(r_field, r_digit)),
        .o_vld     (w_pipe_vld),
        .o_tag     (w_pipe_tag),
        .o_empty   (w_pipe_empty)
    );

    assign o_wr_en    = w_pipe_vld;
    assign o_wr_byte  = w_pipe_vld ? w_pipe_tag : 6'h0;
    assign o_wr_data  = w_pipe_vld ? i_rom_q : 8'h0;
    assign o_skipped  = r_skipped;

endmodule

// File: tb/tb_lag_glyph_sequencer.sv
// Directed bench for lag_glyph_sequencer with a 2-cycle ROM model and per-cycle event log.
module tb_lag_glyph_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  row = 4'd0;
    logic [79:0] bcd = 80'h0;
    logic        rom_rd;
    logic [10:0] rom_addr;
    logic [7:0]  rom_q;
    logic        wr_en;
    logic [5:0]  wr_byte;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic [3:0]  skipped;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int k = 0;

    int          rd_rel[$];
    logic [10:0] rd_addr[$];
    int          wr_rel[$];
    logic [5:0]  wr_byte_q[$];
    logic [7:0]  wr_data_q[$];
    int          done_rel = -1;
    logic [63:0] busy_bits = '0;

    logic [10:0] rq1 = '0, rq2 = '0;

    localparam logic [79:0] T1 = 80'h12345_00042_00100_98765;
    int exp_dig[20]  = '{5,6,7,8,9, 0,0,1,0,0, 2,4,0,0,0, 5,4,3,2,1};
    int exp_byte[20] = '{24,25,27,28,29, 17,18,20,21,22, 10,11,13,14,15, 3,4,6,7,8};

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    lag_glyph_sequencer dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .i_row      (row),
        .i_bcdcount (bcd),
        .o_rom_rd   (rom_rd),
        .o_rom_addr (rom_addr),
        .i_rom_q    (rom_q),
        .o_wr_en    (wr_en),
        .o_wr_byte  (wr_byte),
        .o_wr_data  (wr_data),
        .o_busy     (busy),
        .o_done     (done),
        .o_skipped  (skipped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rq1 <= rom_rd ? rom_addr : 11'h0;
        rq2 <= rq1;
    end
    assign rom_q = rom_f(rq2);

    // Relative cycle n = n-th cycle after the accepting edge.
    always @(negedge clk) begin
        if (rom_rd) begin
            rd_rel.push_back(cyc + 1 - k);
            rd_addr.push_back(rom_addr);
        end
        if (wr_en) begin
            wr_rel.push_back(cyc + 1 - k);
            wr_byte_q.push_back(wr_byte);
            wr_data_q.push_back(wr_data);
        end
        if (done && done_rel < 0) done_rel <= cyc + 1 - k;
        if (busy && (cyc + 1 - k) >= 0 && (cyc + 1 - k) < 64) busy_bits[cyc + 1 - k] <= 1'b1;
    end

    task automatic clear_log();
        rd_rel.delete(); rd_addr.delete(); wr_rel.delete();
        wr_byte_q.delete(); wr_data_q.delete();
        done_rel  = -1;
        busy_bits = '0;
    endtask

    task automatic start_run(input logic [79:0] b, input logic [3:0] r);
        @(negedge clk); #1;
        clear_log();
        bcd   = b;
        row   = r;
        start = 1'b1;
        @(posedge clk); #1;
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (done) ok = 1;
        end
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL done_timeout got=0 want=1"); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rom_rd, wr_en, busy, done, skipped, rom_addr, wr_byte, wr_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs got rd=%b wr=%b busy=%b done=%b skip=%b want all 0",
                     rom_rd, wr_en, busy, done, skipped);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_all_valid();
        start_run(T1, 4'd3);
        wait_done(60);
        n_checks++;
        if (done_rel !== 27) begin n_errors++; $display("FAIL all_valid_done got=%0d want=27", done_rel); end
        n_checks++;
        if (skipped !== 4'b0000) begin n_errors++; $display("FAIL all_valid_skipped got=%b want=0000", skipped); end
        n_checks++;
        if (busy_bits !== 64'h07FF_FFFE) begin n_errors++; $display("FAIL all_valid_busy got=%h want=07fffffe", busy_bits); end
        n_checks++;
        if (rd_rel.size() != 20 || wr_rel.size() != 20) begin
            n_errors++;
            $display("FAIL all_valid_counts got rd=%0d wr=%0d want 20/20", rd_rel.size(), wr_rel.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_checks++;
                if (rd_rel[i] != 2 + i + i / 5 || rd_addr[i] !== 11'h303 + 11'(exp_dig[i] * 16)) begin
                    n_errors++;
                    $display("FAIL all_valid_rd[%0d] got cyc=%0d addr=%h want cyc=%0d addr=%h",
                             i, rd_rel[i], rd_addr[i], 2 + i + i / 5, 11'h303 + 11'(exp_dig[i] * 16));
                end
                n_checks++;
                if (wr_rel[i] != 4 + i + i / 5 || wr_byte_q[i] !== 6'(exp_byte[i]) ||
                    wr_data_q[i] !== rom_f(11'h303 + 11'(exp_dig[i] * 16))) begin
                    n_errors++;
                    $display("FAIL all_valid_wr[%0d] got cyc=%0d byte=%0d data=%h want cyc=%0d byte=%0d data=%h",
                             i, wr_rel[i], wr_byte_q[i], wr_data_q[i], 4 + i + i / 5, exp_byte[i],
                             rom_f(11'h303 + 11'(exp_dig[i] * 16)));
                end
            end
        end
    endtask

    task automatic test_partial_skip();
        start_run({20'h99999, 20'h00000, 20'h99999, 20'h98765}, 4'd0);
        wait_done(60);
        n_checks++;
        if (skipped !== 4'b1110) begin n_errors++; $display("FAIL partial_skipped got=%b want=1110", skipped); end
        n_checks++;
        if (done_rel !== 10) begin n_errors++; $display("FAIL partial_done got=%0d want=10", done_rel); end
        n_checks++;
        if (wr_rel.size() != 5 || rd_rel.size() != 5) begin
            n_errors++;
            $display("FAIL partial_counts got rd=%0d wr=%0d want 5/5", rd_rel.size(), wr_rel.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (wr_byte_q[i] !== 6'(exp_byte[i]) || wr_data_q[i] !== rom_f(11'h300 + 11'(exp_dig[i] * 16))) begin
                    n_errors++;
                    $display("FAIL partial_wr[%0d] got byte=%0d data=%h want byte=%0d data=%h", i,
                             wr_byte_q[i], wr_data_q[i], exp_byte[i], rom_f(11'h300 + 11'(exp_dig[i] * 16)));
                end
            end
        end
    endtask

    task automatic test_all_skipped();
        start_run({20'h99999, 20'h00000, 20'h99999, 20'h99999}, 4'd9);
        wait_done(20);
        n_checks++;
        if (done_rel !== 5) begin n_errors++; $display("FAIL skip_all_done got=%0d want=5", done_rel); end
        n_checks++;
        if (rd_rel.size() != 0 || wr_rel.size() != 0) begin
            n_errors++;
            $display("FAIL skip_all_traffic got rd=%0d wr=%0d want 0/0", rd_rel.size(), wr_rel.size());
        end
        n_checks++;
        if (busy_bits !== 64'h1E) begin n_errors++; $display("FAIL skip_all_busy got=%h want=1e", busy_bits); end
        n_checks++;
        if (skipped !== 4'b1111) begin n_errors++; $display("FAIL skip_all_skipped got=%b want=1111", skipped); end
    endtask

    task automatic test_back_to_back();
        start_run(T1, 4'd3);
        do begin @(negedge clk); #1; end while (cyc + 1 - k < 5);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(60);
        n_checks++;
        if (done_rel !== 27 || rd_rel.size() != 20) begin
            n_errors++;
            $display("FAIL b2b_ignored got done=%0d rd=%0d want 27/20", done_rel, rd_rel.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_done_busy got=%b want=0", busy); end
        clear_log();
        start = 1'b1;
        k     = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_restart_busy got=%b want=1", busy); end
        wait_done(60);
        n_checks++;
        if (done_rel !== 27 || rd_rel.size() != 20) begin
            n_errors++;
            $display("FAIL b2b_second got done=%0d rd=%0d want 27/20", done_rel, rd_rel.size());
        end
    endtask

    task automatic test_snapshot();
        start_run(T1, 4'd7);
        do begin @(negedge clk); #1; end while (cyc + 1 - k < 3);
        bcd = 80'h0;
        row = 4'd0;
        wait_done(60);
        n_checks++;
        if (rd_rel.size() != 20) begin
            n_errors++;
            $display("FAIL snapshot_count got=%0d want=20", rd_rel.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_checks++;
                if (rd_addr[i] !== 11'h307 + 11'(exp_dig[i] * 16)) begin
                    n_errors++;
                    $display("FAIL snapshot_addr[%0d] got=%h want=%h", i, rd_addr[i], 11'h307 + 11'(exp_dig[i] * 16));
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        start_run(T1, 4'd3);
        do begin @(negedge clk); #1; end while (cyc + 1 - k < 10);
        n_checks++;
        if (rom_rd !== 1'b1) begin n_errors++; $display("FAIL midrun_active got rd=%b want=1", rom_rd); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rom_rd, wr_en, busy, done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL midrun_reset got rd=%b wr=%b busy=%b done=%b want 0000", rom_rd, wr_en, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        clear_log();
        repeat (40) @(negedge clk);
        #1;
        n_checks++;
        if (rd_rel.size() != 0 || wr_rel.size() != 0 || done_rel >= 0 || busy_bits !== '0) begin
            n_errors++;
            $display("FAIL post_reset_quiet got rd=%0d wr=%0d done=%0d busy=%h want none",
                     rd_rel.size(), wr_rel.size(), done_rel, busy_bits);
        end
    endtask

    initial begin
        test_reset();
        test_all_valid();
        test_partial_skip();
        test_all_skipped();
        test_back_to_back();
        test_snapshot();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
